// File: rtl/imm_insn_encoder.sv
// imm_insn_encoder: scatters a 32-bit immediate into the RV32I instruction
// field selected by immCntrl, on top of a caller-supplied base word.
// One-deep registered valid/ready stage with a byte-address counter,
// a saturating error counter and an optional halt-on-error state.
module imm_insn_encoder #(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter bit          STOP_ON_ERR = 1'b1,
  parameter int unsigned ERR_CNT_W   = 8
) (
  input  logic                 clk,
  input  logic                 rstN,
  input  logic                 inValid,
  output logic                 inReady,
  input  logic [2:0]           immCntrl,
  input  logic [31:0]          immVal,
  input  logic [31:0]          baseInsn,
  output logic                 outValid,
  input  logic                 outReady,
  output logic [31:0]          insn,
  output logic                 immErr,
  output logic [31:0]          wrAddr,
  output logic [ERR_CNT_W-1:0] errCount,
  output logic                 halted,
  input  logic                 clrErr
);

  typedef enum logic [2:0] {
    IMM_SHAMT = 3'b001,
    IMM_I     = 3'b010,
    IMM_S     = 3'b011,
    IMM_B     = 3'b100,
    IMM_U     = 3'b101,
    IMM_J     = 3'b110
  } imm_t;

  typedef enum logic {RUN, HALT} state_t;

  state_t                 state_q;
  logic                   outValid_q;
  logic [31:0]            insn_q;
  logic                   immErr_q;
  logic [31:0]            wrAddr_q;
  logic [ERR_CNT_W-1:0]   errCount_q;

  logic [31:0]            insn_d;
  logic                   immErr_d;
  logic                   sext12_ok;
  logic                   sext20_ok;
  logic                   in_fire;
  logic                   out_fire;

  assign inReady  = (state_q == RUN) && (!outValid_q || outReady);
  assign in_fire  = inValid && inReady;
  assign out_fire = outValid_q && outReady;

  assign outValid = outValid_q;
  assign insn     = insn_q;
  assign immErr   = immErr_q;
  assign wrAddr   = wrAddr_q;
  assign errCount = errCount_q;
  assign halted   = (state_q == HALT);

  // Field scatter and representability check for the selected immediate type
  always_comb begin
    insn_d    = baseInsn;
    immErr_d  = 1'b0;
    sext12_ok = (&immVal[31:11]) || !(|immVal[31:11]);
    sext20_ok = (&immVal[31:20]) || !(|immVal[31:20]);
    case (imm_t'(immCntrl))
      IMM_SHAMT: begin
        insn_d[24:20] = immVal[4:0];
        immErr_d      = |immVal[31:5];
      end
      IMM_I: begin
        insn_d[31:20] = immVal[11:0];
        immErr_d      = !sext12_ok;
      end
      IMM_S: begin
        insn_d[31:25] = immVal[11:5];
        insn_d[11:7]  = immVal[4:0];
        immErr_d      = !sext12_ok;
      end
      IMM_B: begin
        // immVal is already a halfword offset, so bit 0 is a real field bit
        insn_d[31]    = immVal[11];
        insn_d[7]     = immVal[10];
        insn_d[30:25] = immVal[9:4];
        insn_d[11:8]  = immVal[3:0];
        immErr_d      = !sext12_ok;
      end
      IMM_U: begin
        insn_d[31:12] = immVal[31:12];
        immErr_d      = |immVal[11:0];
      end
      IMM_J: begin
        insn_d[31]    = immVal[20];
        insn_d[19:12] = immVal[19:12];
        insn_d[20]    = immVal[11];
        insn_d[30:21] = immVal[10:1];
        immErr_d      = immVal[0] || !sext20_ok;
      end
      default: begin
        insn_d   = baseInsn;
        immErr_d = 1'b1;
      end
    endcase
  end

  // Output register, address/error counters and halt state machine
  always_ff @(posedge clk) begin
    if (!rstN) begin
      state_q    <= RUN;
      outValid_q <= 1'b0;
      insn_q     <= '0;
      immErr_q   <= 1'b0;
      wrAddr_q   <= BASE_ADDR;
      errCount_q <= '0;
    end else begin
      if (in_fire) begin
        outValid_q <= 1'b1;
        insn_q     <= insn_d;
        immErr_q   <= immErr_d;
      end else if (out_fire) begin
        outValid_q <= 1'b0;
      end

      // A clear in the same cycle as a handshake takes precedence
      if (clrErr) begin
        wrAddr_q   <= BASE_ADDR;
        errCount_q <= '0;
      end else if (out_fire) begin
        wrAddr_q <= wrAddr_q + 32'd4;
        if (immErr_q && (errCount_q != '1))
          errCount_q <= errCount_q + ERR_CNT_W'(1);
      end

      case (state_q)
        RUN:     if (in_fire && immErr_d && STOP_ON_ERR) state_q <= HALT;
        HALT:    if (clrErr) state_q <= RUN;
        default: state_q <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_imm_insn_encoder.sv
// Bench for imm_insn_encoder: directed cases plus randomized traffic, with
// an expectation queue filled at input acceptance and drained by a monitor.
module tb_imm_insn_encoder;

  localparam logic [31:0] BASE = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rstN, inValid, inReady, outValid, outReady, immErr, halted, clrErr;
  logic [2:0]  immCntrl;
  logic [31:0] immVal, baseInsn, insn, wrAddr;
  logic [7:0]  errCount;

  imm_insn_encoder #(.BASE_ADDR(BASE), .STOP_ON_ERR(1'b1), .ERR_CNT_W(8)) dut (
    .clk(clk), .rstN(rstN), .inValid(inValid), .inReady(inReady),
    .immCntrl(immCntrl), .immVal(immVal), .baseInsn(baseInsn),
    .outValid(outValid), .outReady(outReady), .insn(insn), .immErr(immErr),
    .wrAddr(wrAddr), .errCount(errCount), .halted(halted), .clrErr(clrErr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] insn;
    logic        err;
    logic [31:0] val;
    logic [2:0]  ctrl;
  } exp_t;

  exp_t        sb[$];
  int          total = 0;
  int          bad = 0;
  int          rdy_mode = 1;   // 0 random, 1 always ready, 2 never ready
  logic        halted_m = 1'b0;
  logic [31:0] m_addr = BASE;
  logic [7:0]  m_cnt = '0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h @%0t", name, got, want, $time);
    end
  endtask

  // Which immediate bit lands in instruction bit b for type t (-1: none)
  function automatic int src_bit(input logic [2:0] t, input int b);
    case (t)
      3'b001: if (b >= 20 && b <= 24) return b - 20;
      3'b010: if (b >= 20) return b - 20;
      3'b011: begin
        if (b >= 25) return b - 20;
        if (b >= 7 && b <= 11) return b - 7;
      end
      3'b100: begin
        if (b == 31) return 11;
        if (b == 7) return 10;
        if (b >= 25 && b <= 30) return b - 21;
        if (b >= 8 && b <= 11) return b - 8;
      end
      3'b101: if (b >= 12) return b;
      3'b110: begin
        if (b == 31) return 20;
        if (b >= 12 && b <= 19) return b;
        if (b == 20) return 11;
        if (b >= 21 && b <= 30) return b - 20;
      end
      default: return -1;
    endcase
    return -1;
  endfunction

  // Extend stage: gather the field bits back and sign-extend where the type does
  function automatic logic [31:0] m_decode(input logic [31:0] w, input logic [2:0] t);
    logic [31:0] r = '0;
    int top = 31;
    for (int b = 0; b < 32; b++) begin
      int s = src_bit(t, b);
      if (s >= 0) r[s] = w[b];
    end
    if (t == 3'b010 || t == 3'b011 || t == 3'b100) top = 11;
    if (t == 3'b110) top = 20;
    for (int k = top + 1; k < 32; k++) r[k] = r[top];
    return r;
  endfunction

  // Encoder model: scatter bits; a value is representable iff it round-trips
  task automatic m_encode(input logic [2:0] t, input logic [31:0] v, input logic [31:0] base,
                          output logic [31:0] w, output logic e);
    w = base;
    for (int b = 0; b < 32; b++) begin
      int s = src_bit(t, b);
      if (s >= 0) w[b] = v[s];
    end
    e = (t == 3'b000 || t == 3'b111) ? 1'b1 : (m_decode(w, t) != v);
  endtask

  task automatic send(input logic [2:0] t, input logic [31:0] v, input logic [31:0] base,
                      input logic [31:0] exp_insn, input logic exp_err);
    int w = 0;
    exp_t e;
    @(negedge clk);
    #2;
    inValid = 1'b1; immCntrl = t; immVal = v; baseInsn = base;
    #1;
    while (!inReady) begin
      if (++w > 500) begin
        total++; bad++;
        $display("FAIL accept_timeout: got inReady=0 want 1 @%0t", $time);
        inValid = 1'b0;
        return;
      end
      @(negedge clk);
      #3;
    end
    e.insn = exp_insn; e.err = exp_err; e.val = v; e.ctrl = t;
    sb.push_back(e);
    if (exp_err) halted_m = 1'b1;
  endtask

  task automatic send_model(input logic [2:0] t, input logic [31:0] v, input logic [31:0] base);
    logic [31:0] w;
    logic e;
    m_encode(t, v, base, w, e);
    send(t, v, base, w, e);
  endtask

  task automatic idle();
    @(negedge clk);
    #2 inValid = 1'b0;
  endtask

  task automatic do_clear();
    @(negedge clk);
    #2 inValid = 1'b0; clrErr = 1'b1;
    #1 halted_m = 1'b0;
    @(negedge clk);
    #2 clrErr = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 rstN = 1'b0; inValid = 1'b0; clrErr = 1'b0;
    sb.delete();
    halted_m = 1'b0;
    @(negedge clk);
    #2 rstN = 1'b1;
    chk("rst_outValid", {31'b0, outValid}, 32'd0);
    chk("rst_insn", insn, 32'd0);
    chk("rst_immErr", {31'b0, immErr}, 32'd0);
    chk("rst_wrAddr", wrAddr, BASE);
    chk("rst_errCount", {24'b0, errCount}, 32'd0);
    chk("rst_halted", {31'b0, halted}, 32'd0);
  endtask

  // Monitor: drives outReady, compares presented words, tracks address/count model
  initial begin
    logic        fire, fire_err, stall_prev, clr_prev;
    logic [31:0] held_insn, held_addr;
    exp_t        e;
    stall_prev = 1'b0; clr_prev = 1'b0; held_insn = '0; held_addr = '0;
    outReady = 1'b0;
    forever begin
      @(negedge clk);
      case (rdy_mode)
        0:       outReady = ($urandom_range(0, 3) != 0);
        1:       outReady = 1'b1;
        default: outReady = 1'b0;
      endcase
      #1;
      fire = 1'b0; fire_err = 1'b0;
      if (rstN) begin
        chk("errCount", {24'b0, errCount}, {24'b0, m_cnt});
        chk("halted", {31'b0, halted}, {31'b0, halted_m});
        if (halted_m) chk("inReady_halt", {31'b0, inReady}, 32'd0);
        if (stall_prev && outValid) begin
          chk("stall_insn", insn, held_insn);
          if (!clr_prev) chk("stall_addr", wrAddr, held_addr);
        end
        stall_prev = outValid && !outReady;
        held_insn = insn; held_addr = wrAddr;
        if (outValid && outReady) begin
          fire = 1'b1;
          if (sb.size() == 0) begin
            total++; bad++;
            $display("FAIL unexpected_word: got %h want none", insn);
          end else begin
            e = sb.pop_front();
            fire_err = e.err;
            chk("insn", insn, e.insn);
            chk("immErr", {31'b0, immErr}, {31'b0, e.err});
            chk("wrAddr", wrAddr, m_addr);
            if (!e.err) chk("roundtrip", m_decode(insn, e.ctrl), e.val);
          end
        end
      end else begin
        stall_prev = 1'b0;
      end
      #3;
      clr_prev = clrErr;
      if (!rstN) begin
        m_addr = BASE; m_cnt = '0;
      end else if (clrErr) begin
        m_addr = BASE; m_cnt = '0;
      end else if (fire) begin
        m_addr = m_addr + 32'd4;
        if (fire_err && m_cnt != 8'hFF) m_cnt = m_cnt + 8'd1;
      end
    end
  end

  initial begin
    logic [2:0]  t;
    logic [31:0] v;
    int          w;
    rstN = 1'b0; inValid = 1'b0; clrErr = 1'b0;
    immCntrl = '0; immVal = '0; baseInsn = '0;
    repeat (2) @(negedge clk);
    do_reset();

    rdy_mode = 1;
    send(3'b010, 32'hFFFF_F800, 32'h0000_0013, 32'h8000_0013, 1'b0);
    idle();
    do_clear();

    // Back-to-back U then J; J byte offset 0xFFE puts imm[11] into bit 20
    send(3'b101, 32'h1234_5000, 32'h0000_02B7, 32'h1234_52B7, 1'b0);
    send(3'b110, 32'h0000_0FFE, 32'h0000_006F, 32'h7FF0_006F, 1'b0);
    idle();

    // Backpressure
    rdy_mode = 2;
    send_model(3'b011, 32'hFFFF_FFE5, 32'h0020_A023);
    @(negedge clk);
    #2 inValid = 1'b1; immCntrl = 3'b010; immVal = 32'h0000_07FF; baseInsn = 32'h0000_0093;
    for (int i = 0; i < 3; i++) begin
      #1 chk("bp_inReady", {31'b0, inReady}, 32'd0);
      @(negedge clk);
      #2;
    end
    rdy_mode = 1;
    send(3'b010, 32'h0000_07FF, 32'h0000_0093, 32'h7FF0_0093, 1'b0);
    send_model(3'b001, 32'h0000_001F, 32'h0000_1013);
    idle();

    // Error halt and clear
    send(3'b010, 32'h0000_0800, 32'h0000_0013, 32'h8000_0013, 1'b1);
    idle();
    repeat (3) @(negedge clk);
    #1 chk("halt_halted", {31'b0, halted}, 32'd1);
    chk("halt_inReady", {31'b0, inReady}, 32'd0);
    do_clear();
    #1 chk("clr_halted", {31'b0, halted}, 32'd0);
    chk("clr_errCount", {24'b0, errCount}, 32'd0);
    chk("clr_wrAddr", wrAddr, BASE);

    // Illegal and edge types
    send(3'b111, 32'h0000_0004, 32'h1234_5678, 32'h1234_5678, 1'b1);
    idle(); do_clear();
    send(3'b000, 32'h0000_0000, 32'hCAFE_0013, 32'hCAFE_0013, 1'b1);
    idle(); do_clear();
    send(3'b001, 32'd32, 32'h0000_1013, 32'h0000_1013, 1'b1);
    idle(); do_clear();
    send(3'b001, 32'd31, 32'h0000_1013, 32'h01F0_1013, 1'b0);
    send(3'b100, 32'hFFFF_FFFF, 32'h0000_0063, 32'hFE00_0FE3, 1'b0);
    send(3'b110, 32'h0000_0001, 32'h0000_006F, 32'h0000_006F, 1'b1);
    idle(); do_clear();

    // Reset while a word is stalled
    rdy_mode = 2;
    send_model(3'b101, 32'hABCD_E000, 32'h0000_0037);
    idle();
    @(negedge clk);
    do_reset();

    // Randomized traffic
    rdy_mode = 0;
    for (int n = 0; n < 10000; n++) begin
      if (halted_m || $urandom_range(0, 199) == 0) begin
        do_clear();
      end else begin
        t = 3'($urandom_range(0, 7));
        if (t == 3'b000 || t == 3'b111) t = 3'($urandom_range(0, 7));
        if ($urandom_range(0, 9) < 9) v = m_decode($urandom, t);
        else v = $urandom;
        send_model(t, v, $urandom);
        if ($urandom_range(0, 7) == 0) idle();
      end
    end
    idle();

    rdy_mode = 1;
    w = 0;
    while (sb.size() != 0 && w < 200) begin
      @(negedge clk);
      w++;
    end
    chk("drain_empty", sb.size(), 32'd0);
    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
